// File: rtl/rv64_zba_top.sv
// Single-cycle RV64I subset core with Zba, ROM-resident self-test program and a small data RAM.
// Hierarchy DP.regf.Registers exposes the architectural register file.
package rv64_zba_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
      ALU_SH1, ALU_SH2, ALU_SH3, ALU_ADDUW
   } alu_op_t;
endpackage

module rv64_zba_ctrl
   import rv64_zba_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_funct7,
   output logic       o_reg_we,
   output logic       o_mem_we,
   output alu_op_t    o_alu_op,
   output logic       o_use_imm,
   output logic       o_is_store,
   output logic       o_is_load,
   output logic       o_is_branch,
   output logic       o_branch_ne,
   output logic       o_is_jal
);
   always_comb begin
      o_reg_we    = 1'b0;
      o_mem_we    = 1'b0;
      o_alu_op    = ALU_ADD;
      o_use_imm   = 1'b0;
      o_is_store  = 1'b0;
      o_is_load   = 1'b0;
      o_is_branch = 1'b0;
      o_branch_ne = 1'b0;
      o_is_jal    = 1'b0;
      // Anything not matched below falls through as a NOP.
      case (i_opcode)
         7'b0010011: if (i_funct3 == 3'b000) begin
            o_reg_we  = 1'b1;
            o_use_imm = 1'b1;
         end
         7'b0110011: begin
            o_reg_we = 1'b1;
            case ({i_funct7, i_funct3})
               {7'h00, 3'b000}: o_alu_op = ALU_ADD;
               {7'h20, 3'b000}: o_alu_op = ALU_SUB;
               {7'h00, 3'b111}: o_alu_op = ALU_AND;
               {7'h00, 3'b110}: o_alu_op = ALU_OR;
               {7'h00, 3'b100}: o_alu_op = ALU_XOR;
               {7'h00, 3'b010}: o_alu_op = ALU_SLT;
               {7'h10, 3'b010}: o_alu_op = ALU_SH1;
               {7'h10, 3'b100}: o_alu_op = ALU_SH2;
               {7'h10, 3'b110}: o_alu_op = ALU_SH3;
               default:         o_reg_we = 1'b0;
            endcase
         end
         7'b0111011: if ({i_funct7, i_funct3} == {7'h04, 3'b000}) begin
            o_reg_we = 1'b1;
            o_alu_op = ALU_ADDUW;
         end
         7'b0000011: if (i_funct3 == 3'b011) begin
            o_reg_we  = 1'b1;
            o_use_imm = 1'b1;
            o_is_load = 1'b1;
         end
         7'b0100011: if (i_funct3 == 3'b011) begin
            o_mem_we   = 1'b1;
            o_use_imm  = 1'b1;
            o_is_store = 1'b1;
         end
         7'b1100011: if (i_funct3[2:1] == 2'b00) begin
            o_is_branch = 1'b1;
            o_branch_ne = i_funct3[0];
         end
         7'b1101111: begin
            o_reg_we = 1'b1;
            o_is_jal = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

module rv64_zba_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [4:0]  i_rd,
   input  logic        i_we,
   input  logic [63:0] i_wdata,
   output logic [63:0] o_rdata1,
   output logic [63:0] o_rdata2
);
   logic [63:0] Registers [0:31];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) Registers[i] <= '0;
      end else if (i_we && i_rd != 5'd0) begin
         Registers[i_rd] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_rs1 == 5'd0) ? '0 : Registers[i_rs1];
   assign o_rdata2 = (i_rs2 == 5'd0) ? '0 : Registers[i_rs2];
endmodule

module rv64_zba_datapath
   import rv64_zba_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_instr,
   input  logic        i_reg_we,
   input  alu_op_t     i_alu_op,
   input  logic        i_use_imm,
   input  logic        i_is_store,
   input  logic        i_is_load,
   input  logic        i_is_branch,
   input  logic        i_branch_ne,
   input  logic        i_is_jal,
   input  logic [63:0] i_mem_rdata,
   output logic [63:0] o_pc,
   output logic [63:0] o_mem_addr,
   output logic [63:0] o_mem_wdata
);
   logic [63:0] r_pc;
   logic [63:0] w_rs1, w_rs2, w_opb, w_alu, w_wb, w_pc4, w_pc_next;
   logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
   logic        w_taken;

   assign w_imm_i = {{52{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_s = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign w_imm_b = {{51{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign w_imm_j = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   rv64_zba_regfile regf (
      .clk      (clk),
      .rst      (rst),
      .i_rs1    (i_instr[19:15]),
      .i_rs2    (i_instr[24:20]),
      .i_rd     (i_instr[11:7]),
      .i_we     (i_reg_we),
      .i_wdata  (w_wb),
      .o_rdata1 (w_rs1),
      .o_rdata2 (w_rs2)
   );

   assign w_opb = i_use_imm ? (i_is_store ? w_imm_s : w_imm_i) : w_rs2;

   always_comb begin
      case (i_alu_op)
         ALU_SUB:   w_alu = w_rs1 - w_opb;
         ALU_AND:   w_alu = w_rs1 & w_opb;
         ALU_OR:    w_alu = w_rs1 | w_opb;
         ALU_XOR:   w_alu = w_rs1 ^ w_opb;
         ALU_SLT:   w_alu = {63'd0, $signed(w_rs1) < $signed(w_opb)};
         ALU_SH1:   w_alu = {w_rs1[62:0], 1'b0} + w_opb;
         ALU_SH2:   w_alu = {w_rs1[61:0], 2'b0} + w_opb;
         ALU_SH3:   w_alu = {w_rs1[60:0], 3'b0} + w_opb;
         ALU_ADDUW: w_alu = {32'd0, w_rs1[31:0]} + w_opb;
         default:   w_alu = w_rs1 + w_opb;
      endcase
   end

   assign w_pc4   = r_pc + 64'd4;
   assign w_taken = i_is_branch && ((w_rs1 == w_rs2) != i_branch_ne);
   assign w_wb    = i_is_jal ? w_pc4 : (i_is_load ? i_mem_rdata : w_alu);

   always_comb begin
      if (i_is_jal)     w_pc_next = r_pc + w_imm_j;
      else if (w_taken) w_pc_next = r_pc + w_imm_b;
      else              w_pc_next = w_pc4;
   end

   always_ff @(posedge clk) begin
      if (rst) r_pc <= RESET_PC;
      else     r_pc <= w_pc_next;
   end

   assign o_pc        = r_pc;
   assign o_mem_addr  = w_alu;
   assign o_mem_wdata = w_rs2;
endmodule

module rv64_zba_top
   import rv64_zba_pkg::*;
#(
   parameter int          IMEM_WORDS  = 64,
   parameter int          DMEM_DWORDS = 32,
   parameter logic [63:0] RESET_PC    = 64'h0
) (
   input logic clk,
   input logic rst
);
   localparam int IW = $clog2(IMEM_WORDS);
   localparam int DW = $clog2(DMEM_DWORDS);

   logic [31:0] w_instr;
   logic [63:0] w_pc, w_mem_addr, w_mem_wdata, w_mem_rdata;
   logic        w_reg_we, w_mem_we, w_use_imm, w_is_store, w_is_load;
   logic        w_is_branch, w_branch_ne, w_is_jal;
   alu_op_t     w_alu_op;
   logic [63:0] r_dmem [0:DMEM_DWORDS-1] = '{default: '0};
   logic        w_unused;

   always_comb begin
      case (w_pc[IW+1:2])
         'd0:  w_instr = 32'h00500093;
         'd1:  w_instr = 32'h00200113;
         'd2:  w_instr = 32'h01000193;
         'd3:  w_instr = 32'h00108333;
         'd4:  w_instr = 32'h2000A3B3;
         'd5:  w_instr = 32'h2030C433;
         'd6:  w_instr = 32'h407304B3;
         'd7:  w_instr = 32'h00803023;
         'd8:  w_instr = 32'h00003503;
         'd9:  w_instr = 32'h00730463;
         'd10: w_instr = 32'h00100593;
         'd11: w_instr = 32'hFFF00213;
         'd12: w_instr = 32'h0802063B;
         'd13: w_instr = 32'h201166B3;
         'd14: w_instr = 32'h0000006F;
         default: w_instr = 32'h00000013;
      endcase
   end

   rv64_zba_ctrl CTRL (
      .i_opcode    (w_instr[6:0]),
      .i_funct3    (w_instr[14:12]),
      .i_funct7    (w_instr[31:25]),
      .o_reg_we    (w_reg_we),
      .o_mem_we    (w_mem_we),
      .o_alu_op    (w_alu_op),
      .o_use_imm   (w_use_imm),
      .o_is_store  (w_is_store),
      .o_is_load   (w_is_load),
      .o_is_branch (w_is_branch),
      .o_branch_ne (w_branch_ne),
      .o_is_jal    (w_is_jal)
   );

   rv64_zba_datapath #(.RESET_PC(RESET_PC)) DP (
      .clk         (clk),
      .rst         (rst),
      .i_instr     (w_instr),
      .i_reg_we    (w_reg_we),
      .i_alu_op    (w_alu_op),
      .i_use_imm   (w_use_imm),
      .i_is_store  (w_is_store),
      .i_is_load   (w_is_load),
      .i_is_branch (w_is_branch),
      .i_branch_ne (w_branch_ne),
      .i_is_jal    (w_is_jal),
      .i_mem_rdata (w_mem_rdata),
      .o_pc        (w_pc),
      .o_mem_addr  (w_mem_addr),
      .o_mem_wdata (w_mem_wdata)
   );

   // Address bits outside the index field wrap silently.
   assign w_mem_rdata = r_dmem[w_mem_addr[DW+2:3]];

   always_ff @(posedge clk) begin
      if (!rst && w_mem_we) r_dmem[w_mem_addr[DW+2:3]] <= w_mem_wdata;
   end

   assign w_unused = ^{w_pc[63:IW+2], w_pc[1:0], w_mem_addr[63:DW+3], w_mem_addr[2:0]};
endmodule

// File: tb/tb_rv64_zba_top.sv
// Directed bench for rv64_zba_top: runs the ROM self-test and checks architectural state through hierarchy.
module tb_rv64_zba_top;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;
   int   x0_viol = 0;
   bit   mon_en = 1'b0;
   logic [63:0] exp_reg [0:31];

   rv64_zba_top dut (.clk(clk), .rst(rst));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en && dut.DP.regf.Registers[0] !== 64'd0) x0_viol++;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycles(3);
      n_total++;
      if (dut.DP.r_pc !== 64'd0) $display("FAIL reset_pc actual=%h required=0", dut.DP.r_pc);
      else n_pass++;
      for (int i = 0; i < 32; i++) begin
         n_total++;
         if (dut.DP.regf.Registers[i] !== 64'd0)
            $display("FAIL reset_x%0d actual=%h required=0", i, dut.DP.regf.Registers[i]);
         else n_pass++;
      end
      rst = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_main_run();
      int idx [5] = '{6, 7, 8, 9, 11};
      cycles(100);
      n_total++;
      if (dut.DP.r_pc !== 64'h38) $display("FAIL halt_pc_c100 actual=%h required=38", dut.DP.r_pc);
      else n_pass++;
      cycles(400);
      n_total++;
      if (dut.DP.r_pc !== 64'h38) $display("FAIL halt_pc_c500 actual=%h required=38", dut.DP.r_pc);
      else n_pass++;
      foreach (idx[k]) begin
         n_total++;
         if (dut.DP.regf.Registers[idx[k]] !== exp_reg[idx[k]])
            $display("FAIL main_x%0d actual=%h required=%h", idx[k],
                     dut.DP.regf.Registers[idx[k]], exp_reg[idx[k]]);
         else n_pass++;
      end
   endtask

   task automatic test_zba();
      n_total++;
      if (dut.DP.regf.Registers[7] !== 64'd10)
         $display("FAIL sh1add_x7 actual=%h required=a", dut.DP.regf.Registers[7]);
      else n_pass++;
      n_total++;
      if (dut.DP.regf.Registers[8] !== 64'd36)
         $display("FAIL sh2add_x8 actual=%h required=24", dut.DP.regf.Registers[8]);
      else n_pass++;
      n_total++;
      if (dut.DP.regf.Registers[13] !== 64'd21)
         $display("FAIL sh3add_x13 actual=%h required=15", dut.DP.regf.Registers[13]);
      else n_pass++;
      n_total++;
      if (dut.DP.regf.Registers[12] !== 64'h0000_0000_FFFF_FFFF)
         $display("FAIL adduw_x12 actual=%h required=00000000ffffffff", dut.DP.regf.Registers[12]);
      else n_pass++;
   endtask

   task automatic test_memory();
      n_total++;
      if (dut.r_dmem[0] !== 64'd36) $display("FAIL dmem0 actual=%h required=24", dut.r_dmem[0]);
      else n_pass++;
      n_total++;
      if (dut.DP.regf.Registers[10] !== 64'd36)
         $display("FAIL ld_x10 actual=%h required=24", dut.DP.regf.Registers[10]);
      else n_pass++;
   endtask

   task automatic test_control_flow();
      n_total++;
      if (dut.DP.regf.Registers[11] !== 64'd0)
         $display("FAIL beq_skip_x11 actual=%h required=0", dut.DP.regf.Registers[11]);
      else n_pass++;
      for (int i = 0; i < 32; i++) begin
         n_total++;
         if (dut.DP.regf.Registers[i] !== exp_reg[i])
            $display("FAIL final_x%0d actual=%h required=%h", i, dut.DP.regf.Registers[i], exp_reg[i]);
         else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      int nz;
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(300);
      rst = 1'b1;
      cycles(1);
      n_total++;
      if (dut.DP.r_pc !== 64'd0) $display("FAIL midrst_pc actual=%h required=0", dut.DP.r_pc);
      else n_pass++;
      nz = 0;
      for (int i = 0; i < 32; i++) if (dut.DP.regf.Registers[i] !== 64'd0) nz++;
      n_total++;
      if (nz != 0) $display("FAIL midrst_regs_cleared actual=%0d nonzero required=0", nz);
      else n_pass++;
      n_total++;
      if (dut.r_dmem[0] !== 64'd36) $display("FAIL midrst_dmem_kept actual=%h required=24", dut.r_dmem[0]);
      else n_pass++;
      rst = 1'b0;
      cycles(200);
      n_total++;
      if (dut.DP.r_pc !== 64'h38) $display("FAIL rerun_pc actual=%h required=38", dut.DP.r_pc);
      else n_pass++;
      for (int i = 0; i < 32; i++) begin
         n_total++;
         if (dut.DP.regf.Registers[i] !== exp_reg[i])
            $display("FAIL rerun_x%0d actual=%h required=%h", i, dut.DP.regf.Registers[i], exp_reg[i]);
         else n_pass++;
      end
      n_total++;
      if (dut.r_dmem[0] !== 64'd36) $display("FAIL rerun_dmem0 actual=%h required=24", dut.r_dmem[0]);
      else n_pass++;
   endtask

   task automatic test_x0();
      n_total++;
      if (x0_viol != 0) $display("FAIL x0_always_zero actual=%0d bad samples required=0", x0_viol);
      else n_pass++;
      n_total++;
      if (dut.DP.regf.Registers[0] !== 64'd0)
         $display("FAIL x0_final actual=%h required=0", dut.DP.regf.Registers[0]);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) exp_reg[i] = 64'd0;
      exp_reg[1]  = 64'd5;
      exp_reg[2]  = 64'd2;
      exp_reg[3]  = 64'd16;
      exp_reg[4]  = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_reg[6]  = 64'd10;
      exp_reg[7]  = 64'd10;
      exp_reg[8]  = 64'd36;
      exp_reg[10] = 64'd36;
      exp_reg[12] = 64'h0000_0000_FFFF_FFFF;
      exp_reg[13] = 64'd21;

      test_reset();
      test_main_run();
      test_zba();
      test_memory();
      test_control_flow();
      test_mid_reset();
      test_x0();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
